calc_sequencer: RTL and testbench

Operand-entry and execution sequencer for the calculator datapath.
- Consumes pre-edge-detected key pulses.
- Assembles decimal operands and latches the pending operation.
- Runs an internal ALU: single-cycle add/sub, iterative shift-add multiply, iterative restoring divide.
- Presents the value to show plus status to the display path.
- Replaces the bare state tracker with a block that owns operand registers and ALU sequencing.

---
 rtl/calc_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: decimal operand entry, operation latching and an internal
// ALU (single-cycle add/sub, iterative shift-add multiply, iterative
// restoring divide) feeding the display path.
module calc_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             press,
  input  logic [3:0]       button,
  output logic [WIDTH-1:0] display_value,
  output logic [2:0]       state_code,
  output logic [1:0]       op_code,
  output logic             busy,
  output logic             error
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPF    = 3'd1,
    ST_OPR    = 3'd2,
    ST_OPS    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_RESULT = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   f_reg, s_reg, result;
  op_t                op, next_op;
  logic               chain;
  logic [CW-1:0]      counter;

  // Iterative ALU working registers
  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0]   mplier, rem, quo;

  // Key decode
  logic       key_digit, key_op, key_eq, key_clr;
  logic [3:0] op_off;
  op_t        key_opcode;

  // ALU combinational results
  logic [WIDTH:0]     sum_ext, rem_sh, rem_diff;
  logic               rem_ge;
  logic               alu_done, alu_err;
  logic [WIDTH-1:0]   alu_val;
  logic [WIDTH-1:0]   exec_a;

  // X*10+d, dropping the digit when the result would not fit in WIDTH bits
  function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] x,
                                                    input logic [3:0] d);
    logic [WIDTH+3:0] t;
    t = ({4'b0000, x} << 3) + ({4'b0000, x} << 1) + {{WIDTH{1'b0}}, d};
    append_digit = (t[WIDTH+3:WIDTH] != 4'd0) ? x : t[WIDTH-1:0];
  endfunction

  // Classify the incoming key pulse
  always_comb begin
    key_digit  = press && (button <= 4'd9);
    key_op     = press && (button >= 4'hA) && (button <= 4'hD);
    key_eq     = press && (button == 4'hE);
    key_clr    = press && (button == 4'hF);
    op_off     = button - 4'd10;
    key_opcode = op_t'(op_off[1:0]);
  end

  // ALU completion, error detection and result selection for the current op
  always_comb begin
    sum_ext  = {1'b0, f_reg} + {1'b0, s_reg};
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, s_reg};
    rem_ge   = (rem_sh >= {1'b0, s_reg});
    alu_done = 1'b0;
    alu_err  = 1'b0;
    alu_val  = '0;
    case (op)
      OP_ADD: begin
        alu_done = 1'b1;
        alu_err  = sum_ext[WIDTH];
        alu_val  = sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        alu_done = 1'b1;
        alu_err  = (f_reg < s_reg);
        alu_val  = f_reg - s_reg;
      end
      OP_MUL: begin
        alu_done = (counter == CW'(WIDTH));
        alu_err  = |prod[2*WIDTH-1:WIDTH];
        alu_val  = prod[WIDTH-1:0];
      end
      default: begin
        if (s_reg == '0) begin
          alu_done = 1'b1;
          alu_err  = 1'b1;
        end else begin
          alu_done = (counter == CW'(WIDTH));
        end
        alu_val = quo;
      end
    endcase
    // A repeat from RESULT executes on the previous result as first operand
    exec_a = (state == ST_RESULT) ? result : f_reg;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides every state including EXEC
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (key_digit) state_next = ST_OPF;
      ST_OPF:    if (key_op) state_next = ST_OPR;
      ST_OPR:    if (key_digit) state_next = ST_OPS;
      ST_OPS:    if (key_eq || key_op) state_next = ST_EXEC;
      ST_EXEC: begin
        if (alu_done) begin
          if (alu_err)    state_next = ST_ERROR;
          else if (chain) state_next = ST_OPR;
          else            state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (key_eq)         state_next = ST_EXEC;
        else if (key_op)    state_next = ST_OPR;
        else if (key_digit) state_next = ST_OPF;
      end
      default:   state_next = state;
    endcase
    if (key_clr) state_next = ST_IDLE;
  end

  // Operand, op and ALU iteration registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_reg   <= '0;
      s_reg   <= '0;
      result  <= '0;
      op      <= OP_ADD;
      next_op <= OP_ADD;
      chain   <= 1'b0;
      counter <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (key_clr) begin
      f_reg   <= '0;
      s_reg   <= '0;
      result  <= '0;
      op      <= OP_ADD;
      next_op <= OP_ADD;
      chain   <= 1'b0;
      counter <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (key_digit) f_reg <= append_digit('0, button);
        ST_OPF: begin
          if (key_digit)   f_reg <= append_digit(f_reg, button);
          else if (key_op) op <= key_opcode;
        end
        ST_OPR: begin
          if (key_op)         op <= key_opcode;
          else if (key_digit) s_reg <= append_digit('0, button);
        end
        ST_OPS: begin
          if (key_digit) s_reg <= append_digit(s_reg, button);
          else if (key_eq) chain <= 1'b0;
          else if (key_op) begin
            chain   <= 1'b1;
            next_op <= key_opcode;
          end
        end
        ST_EXEC: begin
          if (alu_done) begin
            counter <= '0;
            if (alu_err) begin
              result <= '0;
            end else begin
              result <= alu_val;
              if (chain) begin
                f_reg <= alu_val;
                op    <= next_op;
                s_reg <= '0;
              end
            end
          end else begin
            counter <= counter + CW'(1);
            if (op == OP_MUL) begin
              if (mplier[0]) prod <= prod + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end else begin
              quo <= {quo[WIDTH-2:0], rem_ge};
              rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            end
          end
        end
        ST_RESULT: begin
          if (key_eq) begin
            f_reg <= result;
            chain <= 1'b0;
          end else if (key_op) begin
            f_reg <= result;
            op    <= key_opcode;
          end else if (key_digit) begin
            f_reg <= append_digit('0, button);
          end
        end
        default: ;
      endcase
      // Seed the iterative ALU on every entry into EXEC
      if (state != ST_EXEC && state_next == ST_EXEC) begin
        counter <= '0;
        prod    <= '0;
        mcand   <= {{WIDTH{1'b0}}, exec_a};
        mplier  <= s_reg;
        rem     <= '0;
        quo     <= exec_a;
      end
    end
  end

  // Display and status outputs
  always_comb begin
    display_value = '0;
    case (state)
      ST_OPF, ST_OPR:  display_value = f_reg;
      ST_OPS, ST_EXEC: display_value = s_reg;
      ST_RESULT:       display_value = result;
      default:         display_value = '0;
    endcase
    state_code = state;
    op_code    = op;
    busy       = (state == ST_EXEC);
    error      = (state == ST_ERROR);
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with a result scoreboard.
module tb_calc_sequencer;

  logic        clock;
  logic        reset;
  logic        press;
  logic [3:0]  button;
  logic [31:0] display_value;
  logic [2:0]  state_code;
  logic [1:0]  op_code;
  logic        busy;
  logic        error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  calc_sequencer #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .press(press),
    .button(button),
    .display_value(display_value),
    .state_code(state_code),
    .op_code(op_code),
    .busy(busy),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] k);
    @(negedge clock);
    press  = 1'b1;
    button = k;
    @(negedge clock);
    press  = 1'b0;
    button = 4'd0;
  endtask

  task automatic press_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      int  code;
      c = s[i];
      if (c >= 48 && c <= 57) code = c - 48;
      else                    code = c - 55;
      press_key(4'(code));
    end
  endtask

  // Reference model: op 0 add, 1 sub, 2 mul, 3 div on 32-bit unsigned operands
  task automatic push_model(input int op, input longint unsigned a, input longint unsigned b);
    longint unsigned r;
    logic            e;
    exp_t            x;
    r = 0;
    e = 1'b0;
    case (op)
      0: begin r = a + b; e = (r > 64'hFFFF_FFFF); end
      1: begin e = (a < b); r = e ? 0 : a - b; end
      2: begin r = a * b; e = (r > 64'hFFFF_FFFF); end
      default: begin e = (b == 0); r = e ? 0 : a / b; end
    endcase
    if (e) begin x.st = 3'd6; x.val = 32'd0; end
    else   begin x.st = 3'd5; x.val = r[31:0]; end
    sb.push_back(x);
  endtask

  // Count negedges with busy high; bounded so a stuck EXEC still terminates
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic run_exec(input string tag, input int exp_cycles);
    int   n;
    exp_t x;
    count_busy(n);
    check({tag, "_busy_cycles"}, n, exp_cycles);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, "_state"}, state_code, x.st);
      check({tag, "_display"}, display_value, x.val);
      check({tag, "_error"}, error, (x.st == 3'd6));
      check({tag, "_busy_after"}, busy, 1'b0);
    end
  endtask

  initial begin
    int n;
    reset  = 1'b0;
    press  = 1'b0;
    button = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_state", state_code, 3'd0);
    check("rst_display", display_value, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_op", op_code, 2'd0);
    reset = 1'b1;

    // 12 + 34
    press_seq("12");
    check("add_f_state", state_code, 3'd1);
    check("add_f_display", display_value, 32'd12);
    press_seq("A");
    check("add_opr_state", state_code, 3'd2);
    check("add_opr_op", op_code, 2'd0);
    press_seq("34");
    check("add_s_state", state_code, 3'd3);
    check("add_s_display", display_value, 32'd34);
    push_model(0, 12, 34);
    press_seq("E");
    check("add_exec_display", display_value, 32'd34);
    run_exec("add", 1);

    // 7 * 6
    press_seq("F");
    check("clr_state", state_code, 3'd0);
    press_seq("7C6");
    push_model(2, 7, 6);
    press_seq("E");
    run_exec("mul", 33);

    // 100 / 7
    press_seq("F100D7");
    push_model(3, 100, 7);
    press_seq("E");
    run_exec("div", 33);

    // Divide by zero, then digits ignored, then clear
    press_seq("F5D0");
    push_model(3, 5, 0);
    press_seq("E");
    run_exec("divzero", 1);
    press_seq("3");
    check("err_digit_state", state_code, 3'd6);
    check("err_digit_display", display_value, 32'd0);
    press_seq("E");
    check("err_eq_state", state_code, 3'd6);
    press_seq("F");
    check("err_clr_state", state_code, 3'd0);
    check("err_clr_error", error, 1'b0);

    // 3 - 5 underflows
    press_seq("3B5");
    push_model(1, 3, 5);
    press_seq("E");
    run_exec("sub_under", 1);

    // Chain: 2 + 3, then * 4, then repeat twice
    press_seq("F2A3C");
    count_busy(n);
    check("chain_busy_cycles", n, 1);
    check("chain_state", state_code, 3'd2);
    check("chain_display", display_value, 32'd5);
    check("chain_op", op_code, 2'd2);
    press_seq("4");
    push_model(2, 5, 4);
    press_seq("E");
    run_exec("chain_mul", 33);
    push_model(2, 20, 4);
    press_seq("E");
    run_exec("repeat1", 33);
    push_model(2, 80, 4);
    press_seq("E");
    run_exec("repeat2", 33);

    // Entry overflow: tenth 9 is dropped
    press_seq("F999999999");
    check("ovf_nine_digits", display_value, 32'd999999999);
    press_seq("9");
    check("ovf_dropped", display_value, 32'd999999999);
    check("ovf_state", state_code, 3'd1);

    // Exactly 2^32-1 is accepted; adding 1 carries out
    press_seq("F4294967295");
    check("max_entry", display_value, 32'hFFFF_FFFF);
    press_seq("A1");
    push_model(0, 64'hFFFF_FFFF, 1);
    press_seq("E");
    run_exec("add_carry", 1);

    // Asynchronous reset in the middle of a multiply
    press_seq("F7C6E");
    repeat (5) @(negedge clock);
    check("mid_mul_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", state_code, 3'd0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_display", display_value, 32'd0);
    check("async_rst_op", op_code, 2'd0);
    @(negedge clock);
    reset = 1'b1;

    // Clear in the middle of a divide
    press_seq("100D7E");
    repeat (5) @(negedge clock);
    check("mid_div_busy", busy, 1'b1);
    press_seq("F");
    check("clr_div_state", state_code, 3'd0);
    check("clr_div_busy", busy, 1'b0);
    check("clr_div_display", display_value, 32'd0);

    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
